// File: rtl/lc3_control.sv
// lc3_control: Moore control FSM for the LC-3 datapath. Sequences fetch/decode/execute
// and the multi-cycle memory handshake, decoding every control from the state register.
module lc3_control #(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MIO_EN,
    output logic        Mem_CE_n,
    output logic        Mem_OE_n,
    output logic        Mem_WE_n,
    output logic [4:0]  state_dbg
);
    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_JSR1, S_JSR2,
        S_LDR1, S_LDR_SETUP, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR_SETUP, S_STR3,
        S_PAUSE1, S_PAUSE1_WAIT, S_PAUSE2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state, state_next;
    logic [3:0] wait_cnt;
    logic       load_wait;
    logic       wait_done;

    // Only the opcode and the immediate-select bit steer this block.
    logic unused_ir;
    assign unused_ir = ^{IR[11:6], IR[4:0]};

    assign wait_done = (wait_cnt == 4'd0);
    assign state_dbg = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_HALTED;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (load_wait)
                wait_cnt <= WAIT_LOAD;
            else if (!wait_done)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HALTED:      if (Run) state_next = S_FETCH1;
            S_FETCH1:      state_next = S_FETCH2;
            S_FETCH2:      if (wait_done) state_next = S_FETCH3;
            S_FETCH3:      state_next = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'b0000: state_next = S_BR;
                    4'b0001: state_next = S_ADD;
                    4'b0100: state_next = S_JSR1;
                    4'b0101: state_next = S_AND;
                    4'b0110: state_next = S_LDR1;
                    4'b0111: state_next = S_STR1;
                    4'b1001: state_next = S_NOT;
                    4'b1100: state_next = S_JMP;
                    4'b1101: state_next = S_PAUSE1;
                    default: state_next = S_FETCH1;
                endcase
            end
            S_BR:          state_next = BEN ? S_BR_TAKEN : S_FETCH1;
            S_JSR1:        state_next = S_JSR2;
            // One idle cycle lets the new MAR value settle before the strobes drop.
            S_LDR1:        state_next = S_LDR_SETUP;
            S_LDR_SETUP:   state_next = S_LDR2;
            S_LDR2:        if (wait_done) state_next = S_LDR3;
            S_STR1:        state_next = S_STR2;
            S_STR2:        state_next = S_STR_SETUP;
            S_STR_SETUP:   state_next = S_STR3;
            S_STR3:        if (wait_done) state_next = S_FETCH1;
            S_PAUSE1:      state_next = Continue ? S_PAUSE2 : S_PAUSE1_WAIT;
            S_PAUSE1_WAIT: if (Continue) state_next = S_PAUSE2;
            S_PAUSE2:      if (!Continue) state_next = S_FETCH1;
            S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3:
                           state_next = S_FETCH1;
            default:       state_next = S_HALTED;
        endcase
    end

    assign load_wait = (state_next != state) &&
                       (state_next inside {S_FETCH2, S_LDR2, S_STR3});

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
        MIO_EN = 1'b0;
        Mem_CE_n = 1'b1; Mem_OE_n = 1'b1; Mem_WE_n = 1'b1;
        case (state)
            S_FETCH1: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S_FETCH2, S_LDR2: begin
                Mem_CE_n = 1'b0; Mem_OE_n = 1'b0; MIO_EN = 1'b1;
                LD_MDR = wait_done;
            end
            S_FETCH3:  begin GateMDR = 1'b1; LD_IR = 1'b1; end
            S_DECODE:  LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR2MUX = IR[5]; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state == S_AND) ? 2'b01 : (state == S_NOT) ? 2'b10 : 2'b00;
            end
            S_BR_TAKEN: begin
                ADDR1MUX = 1'b1; ADDR2MUX = 2'b10; PCMUX = 2'b01; LD_PC = 1'b1;
            end
            S_JMP:     begin PCMUX = 2'b01; LD_PC = 1'b1; end
            S_JSR1:    begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            S_JSR2: begin
                ADDR1MUX = 1'b1; ADDR2MUX = 2'b11; PCMUX = 2'b01; LD_PC = 1'b1;
            end
            S_LDR1, S_STR1: begin ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
            S_LDR3:    begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S_STR2: begin
                SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            S_STR3:    begin Mem_CE_n = 1'b0; Mem_WE_n = 1'b0; end
            S_PAUSE1:  LD_LED = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: three controllers (MEM_WAIT 1..3), one active at a time, checked every
// cycle against an expected control-word trace built from the per-instruction rules.
module tb_lc3_control;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en, ce_n, oe_n, we_n;
  } ctl_t;

  localparam int U_IDLE = 0, U_F1 = 1, U_F2 = 2, U_F2L = 3, U_F3 = 4, U_DEC = 5,
                 U_ALU = 6, U_BRT = 7, U_JMP = 8, U_JSR1 = 9, U_JSR2 = 10,
                 U_MAR = 11, U_LDR3 = 12, U_STR2 = 13, U_WRITE = 14, U_LED = 15;

  logic        clk = 1'b0;
  logic [2:0]  rst_n = 3'b000;
  logic        run = 1'b0, cont = 1'b0, ben = 1'b0;
  logic [15:0] ir = 16'h0000;
  ctl_t        obs [3];
  logic [4:0]  unused_dbg [3];

  int          n_checks = 0, n_fail = 0, sel = 0;
  logic [25:0] exp_q[$];
  logic        cont_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en, ce_n, oe_n, we_n;
    lc3_control #(.MEM_WAIT(g + 1)) dut (
      .Clk(clk), .Reset_n(rst_n[g]), .Run(run), .Continue(cont), .IR(ir), .BEN(ben),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben), .LD_CC(ld_cc),
      .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
      .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk), .DRMUX(drmux), .SR1MUX(sr1mux),
      .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .MIO_EN(mio_en),
      .Mem_CE_n(ce_n), .Mem_OE_n(oe_n), .Mem_WE_n(we_n), .state_dbg(unused_dbg[g])
    );
    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                     gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, aluk,
                     drmux, sr1mux, sr2mux, addr1mux, mio_en, ce_n, oe_n, we_n};
  end

  // Control word each step of an instruction must present.
  function automatic ctl_t uop(input int u, input logic [1:0] aluk, input logic ir5);
    ctl_t c = '0;
    c.ce_n = 1'b1; c.oe_n = 1'b1; c.we_n = 1'b1;
    case (u)
      U_F1:    begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      U_F2:    begin c.ce_n = 0; c.oe_n = 0; c.mio_en = 1; end
      U_F2L:   begin c.ce_n = 0; c.oe_n = 0; c.mio_en = 1; c.ld_mdr = 1; end
      U_F3:    begin c.gate_mdr = 1; c.ld_ir = 1; end
      U_DEC:   c.ld_ben = 1;
      U_ALU:   begin c.sr2mux = ir5; c.aluk = aluk; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      U_BRT:   begin c.addr1mux = 1; c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
      U_JMP:   begin c.pcmux = 2'b01; c.ld_pc = 1; end
      U_JSR1:  begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      U_JSR2:  begin c.addr1mux = 1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; end
      U_MAR:   begin c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; end
      U_LDR3:  begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      U_STR2:  begin c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
      U_WRITE: begin c.ce_n = 0; c.we_n = 0; end
      U_LED:   c.ld_led = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input int u, input logic [1:0] aluk, input logic ir5, input logic c);
    exp_q.push_back(uop(u, aluk, ir5));
    cont_q.push_back(c);
  endtask

  task automatic push_r(input int u);
    push(u, 2'b00, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_mem_read(input int w);
    for (int k = 0; k < w; k++) push_r((k == w - 1) ? U_F2L : U_F2);
  endtask

  // Expected trace from FETCH1 up to (not including) the next FETCH1.
  task automatic build(input logic [15:0] i, input logic b, input int w,
                       input int zeros, input int ones);
    int  k;
    int  ph;
    logic c;
    push_r(U_F1);
    push_mem_read(w);
    push_r(U_F3);
    push_r(U_DEC);
    case (i[15:12])
      4'b0000: begin push_r(U_IDLE); if (b) push_r(U_BRT); end
      4'b0001: push(U_ALU, 2'b00, i[5], 1'($urandom_range(0, 1)));
      4'b0101: push(U_ALU, 2'b01, i[5], 1'($urandom_range(0, 1)));
      4'b1001: push(U_ALU, 2'b10, i[5], 1'($urandom_range(0, 1)));
      4'b1100: push_r(U_JMP);
      4'b0100: begin push_r(U_JSR1); push_r(U_JSR2); end
      4'b0110: begin push_r(U_MAR); push_r(U_IDLE); push_mem_read(w); push_r(U_LDR3); end
      4'b0111: begin
        push_r(U_MAR); push_r(U_STR2); push_r(U_IDLE);
        for (int j = 0; j < w; j++) push_r(U_WRITE);
      end
      4'b1101: begin
        k = 0; ph = 1;
        while (1) begin
          c = (k >= zeros) && (k < zeros + ones);
          push((k == 0) ? U_LED : U_IDLE, 2'b00, 1'b0, c);
          if (ph == 1 && c) ph = 2;
          else if (ph == 2 && !c) break;
          k++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input ctl_t e);
    n_checks++;
    assert (obs[sel] === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs[sel], e);
    end
  endtask

  // Called while the active DUT sits in FETCH1; leaves it in the following FETCH1.
  task automatic exec(input logic [15:0] i, input logic b, input int zeros, input int ones);
    int k = 0;
    ir = i; ben = b;
    build(i, b, sel + 1, zeros, ones);
    while (exp_q.size() > 0) begin
      check($sformatf("w%0d_ir%h_c%0d", sel + 1, i, k), ctl_t'(exp_q.pop_front()));
      cont = cont_q.pop_front();
      run = 1'($urandom_range(0, 1));
      k++;
      tick();
    end
  endtask

  task automatic exec_rand(input int n);
    logic [3:0] op;
    for (int j = 0; j < n; j++) begin
      op = 4'($urandom_range(0, 15));
      exec({op, 12'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(1, 3));
    end
  endtask

  task automatic start_dut(input int s);
    sel = s; rst_n = 3'b000; run = 0; cont = 0;
    tick();
    check("reset_state", uop(U_IDLE, 2'b00, 1'b0));
    rst_n[s] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("halted_idle", uop(U_IDLE, 2'b00, 1'b0));
      ir = 16'($urandom); cont = 1'($urandom_range(0, 1)); run = 0;
    end
    run = 1;
    tick();
    run = 0;
  endtask

  initial begin
    ctl_t e;
    int   seen;
    // MEM_WAIT = 2: directed, then random.
    start_dut(1);
    exec(16'h1042, 1'b0, 0, 1);
    exec(16'h0E05, 1'b1, 0, 1);
    exec(16'h0E05, 1'b0, 0, 1);
    exec(16'hD000, 1'b0, 10, 3);
    exec(16'hD000, 1'b0, 0, 2);
    exec(16'hF025, 1'b1, 0, 1);
    exec(16'h1062, 1'b0, 0, 1);
    exec_rand(30);
    check("final_fetch1_w2", uop(U_F1, 2'b00, 1'b0));

    // MEM_WAIT = 1: single-cycle accesses.
    start_dut(0);
    exec(16'h6283, 1'b0, 0, 1);
    exec(16'h4801, 1'b0, 0, 1);
    exec_rand(30);
    check("final_fetch1_w1", uop(U_F1, 2'b00, 1'b0));

    // MEM_WAIT = 3, ending with an asynchronous reset during the write strobe.
    start_dut(2);
    exec(16'h7283, 1'b0, 0, 1);
    exec_rand(20);
    ir = 16'h7283;
    build(ir, 1'b0, 3, 0, 1);
    seen = 0;
    while (exp_q.size() > 0) begin
      e = ctl_t'(exp_q.pop_front());
      cont = cont_q.pop_front();
      check("str_before_reset", e);
      if (!e.we_n) seen++;
      if (seen == 2) break;
      tick();
    end
    exp_q.delete();
    cont_q.delete();
    #1 rst_n[2] = 1'b0;
    #1 check("reset_mid_str3", uop(U_IDLE, 2'b00, 1'b0));
    tick();
    check("held_in_reset", uop(U_IDLE, 2'b00, 1'b0));
    rst_n[2] = 1'b1;
    run = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("halted_after_reset", uop(U_IDLE, 2'b00, 1'b0));
      ir = 16'($urandom); cont = 1'($urandom_range(0, 1)); ben = 1'($urandom_range(0, 1));
    end
    run = 1;
    tick();
    run = 0;
    exec(16'h1042, 1'b0, 0, 1);
    check("final_fetch1_w3", uop(U_F1, 2'b00, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lc3_control.md
# lc3_control

Moore-style control state machine driving the LC-3 datapath. Each instruction runs through fetch, decode and execute. For every state the block issues the register load enables, bus gates and mux selects the datapath consumes. It also sequences the multi-cycle memory handshake: MAR/MDR setup, chip enables and wait states. The block sits beside the datapath in the Lab 6 top level, with memory between them via the MIO path.

## Interface
- MEM_WAIT, default 2: cycles memory needs per access. Legal range 1–15.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  level; starts execution from HALTED.
- Continue  in  1  level; releases PAUSE.
- IR  in  16  current instruction, from the datapath.
- BEN  in  1  branch-enable flag, from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one is high in any state.
- PCMUX  out  2  00 PC+1, 01 address sum, 10 bus.
- ADDR2MUX  out  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
- ALUK  out  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A.
- DRMUX  out  1  0 = IR[11:9], 1 = R7.
- SR1MUX  out  1  0 = IR[8:6], 1 = IR[11:9].
- SR2MUX  out  1  0 = SR2 register, 1 = sext IR[4:0].
- ADDR1MUX  out  1  0 = SR1, 1 = PC.
- MIO_EN  out  1  MDR input select: 1 = memory, 0 = bus.
- Mem_CE_n, Mem_OE_n, Mem_WE_n  out  1 each  active-low memory strobes.

## Operation
- Opcode map, IR[15:12]: BR 0000, ADD 0001, JSR 0100, AND 0101, LDR 0110, STR 0111, NOT 1001, JMP 1100, PAUSE 1101. Any other opcode goes from DECODE straight to FETCH1 with no side effects.
- HALTED: all outputs inactive. Moves to FETCH1 when Run = 1.
- FETCH1: GatePC, LD_MAR, LD_PC, PCMUX = 00.
- FETCH2: Mem_CE_n = Mem_OE_n = 0, MIO_EN = 1. Held for MEM_WAIT cycles by a wait counter. LD_MDR is asserted only on the last cycle.
- FETCH3: GateMDR, LD_IR.
- DECODE: LD_BEN. Branches on the opcode.
- ADD and AND: SR1MUX = 0, SR2MUX = IR[5], ALUK = 00 or 01, GateALU, DRMUX = 0, LD_REG, LD_CC.
- NOT: same as ADD/AND but ALUK = 10.
- BR: if BEN = 1, go to BR_TAKEN; otherwise go to FETCH1.
- BR_TAKEN: ADDR1MUX = 1, ADDR2MUX = 10, PCMUX = 01, LD_PC.
- JMP: SR1MUX = 0, ADDR1MUX = 0, ADDR2MUX = 00, PCMUX = 01, LD_PC.
- JSR1: GatePC, DRMUX = 1, LD_REG.
- JSR2: ADDR1MUX = 1, ADDR2MUX = 11, PCMUX = 01, LD_PC.
- LDR1: ADDR1MUX = 0, SR1MUX = 0, ADDR2MUX = 01, GateMARMUX, LD_MAR.
- LDR2: identical to FETCH2.
- LDR3: GateMDR, DRMUX = 0, LD_REG, LD_CC.
- STR1: identical to LDR1.
- STR2: SR1MUX = 1, ALUK = 11, GateALU, MIO_EN = 0, LD_MDR.
- STR3: Mem_CE_n = Mem_WE_n = 0, held for MEM_WAIT cycles. Mem_OE_n stays 1.
- PAUSE1: LD_LED pulses for one cycle, then the FSM holds in PAUSE1 until Continue = 1.
- PAUSE2: holds until Continue = 0, then goes to FETCH1.
- Every other execute state returns to FETCH1.
- Run is sampled only in HALTED. Dropping Run mid-program has no effect.

## Timing
- Reset state: state = HALTED, wait counter = 0.
  - All LD_*, Gate*, mux selects, MIO_EN and ALUK are 0.
  - All Mem_*_n are 1.
  - Reset applies immediately on the falling edge of Reset_n, even in the middle of STR3. Mem_WE_n must rise without waiting for Clk.
- Outputs are decoded combinationally from the state register, plus IR[5] for SR2MUX. There is no output register, so load enables take effect at the edge that leaves the state.
- Cycle counts per instruction, with W = MEM_WAIT:
  - ADD, AND, NOT, JMP: 4+W.
  - BR not taken: 4+W. BR taken: 5+W.
  - JSR: 5+W.
  - LDR: 6+2W.
  - STR: 6+2W.
- Wait counter behaviour:
  - Loads W−1 on entry to FETCH2, LDR2 or STR3.
  - Decrements each cycle; the state exits when the count is 0.
  - With W = 1 the access lasts exactly one cycle.
- Memory strobes never overlap: Mem_OE_n and Mem_WE_n are never both 0.
- Continue already high on entry to PAUSE1: LD_LED is still asserted for one cycle, then the FSM advances to PAUSE2.

## Test plan
- Reset, then Run = 1 for 1 cycle, MEM_WAIT = 2, IR = 0x1042 (ADD R0,R1,R2) → FETCH1 at cycle 1, LD_IR at cycle 4, LD_REG/LD_CC/GateALU at cycle 6 with SR2MUX = 0 and ALUK = 00, back in FETCH1 at cycle 7.
- IR = 0x0E05 (BRnzp +5) with BEN = 1 → BR_TAKEN asserts LD_PC with PCMUX = 01, ADDR2MUX = 10, ADDR1MUX = 1. With BEN = 0 → FETCH1 directly, and LD_PC is never asserted outside fetch.
- IR = 0x7283 (STR R1,R2,#3), MEM_WAIT = 3 → Mem_WE_n low for exactly 3 consecutive cycles, Mem_OE_n high throughout, LD_MDR with MIO_EN = 0 in STR2.
- IR = 0x6283 (LDR), MEM_WAIT = 1 → LDR2 lasts 1 cycle with LD_MDR and MIO_EN = 1. LDR3 asserts GateMDR, LD_REG, LD_CC. Total 8 cycles.
- IR = 0xD000 (PAUSE), Continue held 0 for 10 cycles, then 1 for 3, then 0 → LD_LED high exactly once, FSM stays in PAUSE1 through the 10 cycles, FETCH1 one cycle after Continue falls.
- Reset_n driven low mid-STR3 between clock edges → Mem_WE_n = 1 and all outputs inactive in the same delta. FSM is in HALTED after release and ignores activity until Run = 1.
